// File: rtl/pipelined_alu_stage_if.sv
// Request/result bundle for pipelined_alu_stage: issue handshake, operands, result handshake
// and status flags. master drives requests, slave is the execute stage.
interface pipelined_alu_stage_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 16
);
  logic                 inValid;
  logic                 inReady;
  logic [WIDTH-1:0]     operandA;
  logic [WIDTH-1:0]     operandB;
  logic [IMM_WIDTH-1:0] immediate;
  logic [1:0]           sourceSelect;
  logic [3:0]           aluControl;
  logic                 outValid;
  logic                 outReady;
  logic [WIDTH-1:0]     result;
  logic                 compareResult;
  logic                 overflow;
  logic                 stickyOverflow;
  logic                 clearSticky;
  logic                 busy;

  modport master (
    output inValid, operandA, operandB, immediate, sourceSelect, aluControl, outReady,
           clearSticky,
    input  inReady, outValid, result, compareResult, overflow, stickyOverflow, busy
  );

  modport slave (
    input  inValid, operandA, operandB, immediate, sourceSelect, aluControl, outReady,
           clearSticky,
    output inReady, outValid, result, compareResult, overflow, stickyOverflow, busy
  );
endinterface

// File: rtl/pipelined_alu_stage.sv
// Two-stage execute unit: issue register (S1) then output register (S2) with valid/ready.
// Define ALU_MUL_EN to enable op 11 as an iterative WIDTH-cycle unsigned shift-add multiply.
module pipelined_alu_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IMM_WIDTH = 16
) (
  input logic                   clock,
  input logic                   reset,
  pipelined_alu_stage_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSlt  = 4'd5;
  localparam logic [3:0] OpSltu = 4'd6;
  localparam logic [3:0] OpSll  = 4'd7;
  localparam logic [3:0] OpSrl  = 4'd8;
  localparam logic [3:0] OpSra  = 4'd9;
  localparam logic [3:0] OpEq   = 4'd10;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q, s1_b_q;
  logic [3:0]       s1_op_q;
  logic             out_valid_q, cmp_q, ovf_q, sticky_q;
  logic [WIDTH-1:0] result_q;

  logic             s2_adv, s1_adv, accept, op_done;
  logic [WIDTH-1:0] op_b, sum, diff, alu_res;
  logic             alu_cmp, alu_ovf, cmp_bit, is_cmp, legal;

  assign s2_adv      = !out_valid_q || bus.outReady;
  assign s1_adv      = s1_valid_q && op_done && s2_adv;
  // Held low while reset is asserted so nothing is accepted into a clearing pipeline.
  assign bus.inReady = !reset && (!s1_valid_q || s1_adv);
  assign accept      = bus.inValid && bus.inReady;

  always_comb begin
    op_b = bus.operandB;
    unique case (bus.sourceSelect)
      2'b00: op_b = bus.operandB;
      2'b01: op_b = WIDTH'($signed(bus.immediate));
      2'b10: op_b = WIDTH'(bus.immediate);
      2'b11: op_b = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0]  OpMul = 4'd11;
  localparam int unsigned CW    = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDone} mul_state_e;

  mul_state_e         state_q;
  logic [2*WIDTH-1:0] prod_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, mul_start;

  assign mul_start = accept && (bus.aluControl == OpMul);
  assign op_done   = (s1_op_q != OpMul) || (state_q == StDone);
  assign bus.busy  = busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (mul_start) begin
            state_q  <= StMul;
            prod_q   <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, bus.operandA};
            mplier_q <= op_b;
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
          end
        end
        StMul: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
          end
        end
        StDone: begin
          // A new multiply may be issued in the same cycle the finished one leaves S1.
          if (s1_adv) begin
            if (mul_start) begin
              state_q  <= StMul;
              prod_q   <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, bus.operandA};
              mplier_q <= op_b;
              cnt_q    <= CW'(WIDTH);
              busy_q   <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  assign op_done  = 1'b1;
  assign bus.busy = 1'b0;
`endif

  assign sum  = s1_a_q + s1_b_q;
  assign diff = s1_a_q - s1_b_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    cmp_bit = 1'b0;
    is_cmp  = 1'b0;
    legal   = 1'b1;
    case (s1_op_q)
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) && (diff[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      OpAnd:  alu_res = s1_a_q & s1_b_q;
      OpOr:   alu_res = s1_a_q | s1_b_q;
      OpXor:  alu_res = s1_a_q ^ s1_b_q;
      OpSlt:  begin is_cmp = 1'b1; cmp_bit = $signed(s1_a_q) < $signed(s1_b_q); end
      OpSltu: begin is_cmp = 1'b1; cmp_bit = s1_a_q < s1_b_q; end
      OpSll:  alu_res = s1_a_q << s1_b_q[SHW-1:0];
      OpSrl:  alu_res = s1_a_q >> s1_b_q[SHW-1:0];
      OpSra:  alu_res = WIDTH'($signed(s1_a_q) >>> s1_b_q[SHW-1:0]);
      OpEq:   begin is_cmp = 1'b1; cmp_bit = s1_a_q == s1_b_q; end
`ifdef ALU_MUL_EN
      OpMul: begin
        alu_res = prod_q[WIDTH-1:0];
        alu_ovf = |prod_q[2*WIDTH-1:WIDTH];
      end
`endif
      default: legal = 1'b0;
    endcase
    if (is_cmp) alu_res = {{(WIDTH-1){1'b0}}, cmp_bit};
    alu_cmp = is_cmp ? cmp_bit : (legal && (alu_res == '0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= bus.operandA;
      s1_b_q     <= op_b;
      s1_op_q    <= bus.aluControl;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cmp_q       <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid_q <= s1_adv;
        if (s1_adv) begin
          result_q <= alu_res;
          cmp_q    <= alu_cmp;
          ovf_q    <= alu_ovf;
        end
      end
      // Set has priority over a same-cycle clear.
      if (out_valid_q && bus.outReady && ovf_q) sticky_q <= 1'b1;
      else if (bus.clearSticky)                 sticky_q <= 1'b0;
    end
  end

  assign bus.outValid       = out_valid_q;
  assign bus.result         = result_q;
  assign bus.compareResult  = cmp_q;
  assign bus.overflow       = ovf_q;
  assign bus.stickyOverflow = sticky_q;
endmodule

// File: tb/tb_pipelined_alu_stage.sv
// Self-checking bench for pipelined_alu_stage: directed scenarios plus a randomized stream
// checked against a queue-based reference model. Honours ALU_MUL_EN when defined.
module tb_pipelined_alu_stage;
  localparam int unsigned W = 32;

  logic clock, reset;
  int   n_cmp, n_fail;

  pipelined_alu_stage_if #(.WIDTH(W), .IMM_WIDTH(16)) bus ();

  pipelined_alu_stage #(.WIDTH(W), .IMM_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] imm;
    logic [31:0] r;
    logic        c;
    logic        v;
  } vec_t;

  function automatic logic [31:0] sel_b(input logic [1:0] sel, input logic [31:0] b,
                                        input logic [15:0] imm);
    int signed simm;
    simm = int'($signed(imm));
    case (sel)
      2'b00:   return b;
      2'b01:   return 32'(simm);
      2'b10:   return {16'h0000, imm};
      default: return 32'h0;
    endcase
  endfunction

  // Reference computed with wide signed/unsigned arithmetic rather than bit tricks.
  function automatic exp_t ref_alu(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op);
    exp_t        e;
    longint      sa, sb, s;
    logic [63:0] p;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    e.r = 32'h0;
    e.v = 1'b0;
    case (op)
      4'd0:  begin s = sa + sb; e.r = s[31:0]; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1:  begin s = sa - sb; e.r = s[31:0]; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2:  e.r = a & b;
      4'd3:  e.r = a | b;
      4'd4:  e.r = a ^ b;
      4'd5:  e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  e.r = (a < b) ? 32'd1 : 32'd0;
      4'd7:  e.r = a << sh;
      4'd8:  e.r = a >> sh;
      4'd9:  begin s = sa >>> sh; e.r = s[31:0]; end
      4'd10: e.r = (a == b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd11: begin p = {32'h0, a} * {32'h0, b}; e.r = p[31:0]; e.v = p[63:32] != 32'h0; end
`endif
      default: e.r = 32'h0;
    endcase
    if (op == 4'd5 || op == 4'd6 || op == 4'd10) e.c = e.r[0];
`ifdef ALU_MUL_EN
    else if (op <= 4'd11) e.c = (e.r == 32'h0);
`else
    else if (op <= 4'd10) e.c = (e.r == 32'h0);
`endif
    else e.c = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0:       return 32'h7FFFFFFF;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h0;
      4:       return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.inValid = 1'b0; bus.operandA = '0; bus.operandB = '0; bus.immediate = '0;
    bus.sourceSelect = 2'b00; bus.aluControl = 4'd0; bus.outReady = 1'b1;
    bus.clearSticky = 1'b0;
  endtask

  // Empties the pipeline and leaves stickyOverflow cleared; enters/leaves at posedge+1.
  task automatic drain();
    idle_inputs();
    bus.clearSticky = 1'b1;
    repeat (40) @(posedge clock);
    #1 bus.clearSticky = 1'b0;
  endtask

  task automatic send_one(input logic [3:0] op, input logic [1:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [15:0] imm, output exp_t got_e,
                          output int lat, output int busy_cnt, output logic got);
    bus.aluControl = op; bus.sourceSelect = sel; bus.operandA = a; bus.operandB = b;
    bus.immediate = imm; bus.inValid = 1'b1; bus.outReady = 1'b1;
    got = 1'b0; lat = 0; busy_cnt = 0; got_e = '{32'h0, 1'b0, 1'b0};
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.inReady) break;
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    bus.inValid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.busy) busy_cnt++;
      if (bus.outValid) begin
        got_e = '{bus.result, bus.compareResult, bus.overflow};
        got = 1'b1;
        break;
      end
      @(posedge clock); #1;
      lat++;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    exp_t e; int lat, bc; logic got, stale;
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({bus.inReady, bus.outValid, bus.result, bus.compareResult, bus.overflow,
         bus.stickyOverflow, bus.busy} !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_state: inReady=%b outValid=%b result=%h cmp=%b ovf=%b sticky=%b busy=%b, want all 0",
               bus.inReady, bus.outValid, bus.result, bus.compareResult, bus.overflow,
               bus.stickyOverflow, bus.busy);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.inReady !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: inReady=%b want 1", bus.inReady);
    end
    @(posedge clock); #1;
    send_one(4'd0, 2'b00, 32'h7FFFFFFF, 32'h1, 16'h0, e, lat, bc, got);
    @(negedge clock);
    n_cmp++;
    if (bus.stickyOverflow !== 1'b1) begin
      n_fail++; $display("FAIL sticky_before_reset: sticky=%b want 1", bus.stickyOverflow);
    end
    @(posedge clock); #1;
    bus.outReady = 1'b0; bus.aluControl = 4'd0; bus.operandA = 32'd1; bus.operandB = 32'd2;
    bus.inValid = 1'b1;
    repeat (3) @(posedge clock);
    #1 bus.inValid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.outValid !== 1'b1) begin
      n_fail++; $display("FAIL pending_before_reset: outValid=%b want 1", bus.outValid);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.outValid, bus.result, bus.stickyOverflow, bus.busy, bus.inReady} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_midstream: outValid=%b result=%h sticky=%b busy=%b inReady=%b, want all 0",
               bus.outValid, bus.result, bus.stickyOverflow, bus.busy, bus.inReady);
    end
    @(posedge clock); #1 reset = 1'b0; bus.outReady = 1'b1;
    stale = 1'b0;
    repeat (20) begin
      @(negedge clock); if (bus.outValid) stale = 1'b1;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL stale_after_reset: saw outValid=1, want none");
    end
`ifdef ALU_MUL_EN
    bus.aluControl = 4'd11; bus.operandA = 32'd3; bus.operandB = 32'd4; bus.inValid = 1'b1;
    @(posedge clock); #1 bus.inValid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_mid_mul: busy=%b want 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_mul: busy=%b want 0", bus.busy);
    end
    @(posedge clock); #1 reset = 1'b0;
    stale = 1'b0;
    repeat (40) begin
      @(negedge clock); if (bus.outValid) stale = 1'b1;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (stale !== 1'b0) begin
      n_fail++; $display("FAIL stale_after_mul_reset: saw outValid=1, want none");
    end
`endif
  endtask

  task automatic test_throughput();
    logic ready_ok;
    drain();
    ready_ok = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      bus.inValid = (k < 10); bus.operandA = 32'(k); bus.operandB = 32'd1;
      bus.aluControl = 4'd0; bus.sourceSelect = 2'b00; bus.outReady = 1'b1;
      @(negedge clock);
      if (k < 10 && bus.inReady !== 1'b1) ready_ok = 1'b0;
      n_cmp++;
      if (k >= 2 && k <= 11) begin
        if (bus.outValid !== 1'b1 || bus.result !== 32'(k - 1)) begin
          n_fail++;
          $display("FAIL throughput_c%0d: outValid=%b result=%0d want outValid=1 result=%0d",
                   k, bus.outValid, bus.result, k - 1);
        end
      end else if (bus.outValid !== 1'b0) begin
        n_fail++; $display("FAIL throughput_c%0d: outValid=%b want 0", k, bus.outValid);
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (ready_ok !== 1'b1) begin
      n_fail++; $display("FAIL throughput_ready: inReady dropped, want constant 1");
    end
  endtask

  task automatic test_imm_flags();
    vec_t tv[12];
    exp_t e; int lat, bc; logic got;
    tv[0]  = '{"sub_imm",  4'd1,  2'b01, 32'd5,        32'd0,        16'hFFFF, 32'd6,        1'b0, 1'b0};
    tv[1]  = '{"eq",       4'd10, 2'b00, 32'd7,        32'd7,        16'h0,    32'd1,        1'b1, 1'b0};
    tv[2]  = '{"slt",      4'd5,  2'b00, 32'hFFFFFFFF, 32'd1,        16'h0,    32'd1,        1'b1, 1'b0};
    tv[3]  = '{"sltu",     4'd6,  2'b00, 32'hFFFFFFFF, 32'd1,        16'h0,    32'd0,        1'b0, 1'b0};
    tv[4]  = '{"add_zext", 4'd0,  2'b10, 32'd1,        32'd0,        16'hFFFF, 32'h00010000, 1'b0, 1'b0};
    tv[5]  = '{"or_zero",  4'd3,  2'b11, 32'd0,        32'hDEADBEEF, 16'h0,    32'd0,        1'b1, 1'b0};
    tv[6]  = '{"illegal",  4'd13, 2'b00, 32'd5,        32'd5,        16'h0,    32'd0,        1'b0, 1'b0};
    tv[7]  = '{"sra",      4'd9,  2'b00, 32'h80000000, 32'd36,       16'h0,    32'hF8000000, 1'b0, 1'b0};
    tv[8]  = '{"sub_ovf",  4'd1,  2'b00, 32'h80000000, 32'd1,        16'h0,    32'h7FFFFFFF, 1'b0, 1'b1};
    tv[9]  = '{"xor_zero", 4'd4,  2'b00, 32'hA5A5A5A5, 32'hA5A5A5A5, 16'h0,    32'd0,        1'b1, 1'b0};
    tv[10] = '{"sll",      4'd7,  2'b00, 32'd1,        32'd31,       16'h0,    32'h80000000, 1'b0, 1'b0};
    tv[11] = '{"srl",      4'd8,  2'b00, 32'h80000000, 32'd31,       16'h0,    32'd1,        1'b0, 1'b0};
    drain();
    foreach (tv[i]) begin
      send_one(tv[i].op, tv[i].sel, tv[i].a, tv[i].b, tv[i].imm, e, lat, bc, got);
      n_cmp++;
      if (got !== 1'b1 || e.r !== tv[i].r || e.c !== tv[i].c || e.v !== tv[i].v || lat != 1) begin
        n_fail++;
        $display("FAIL %s: got=%b result=%h cmp=%b ovf=%b lat=%0d want result=%h cmp=%b ovf=%b lat=1",
                 tv[i].name, got, e.r, e.c, e.v, lat, tv[i].r, tv[i].c, tv[i].v);
      end
    end
  endtask

  task automatic test_overflow_sticky();
    exp_t e; int lat, bc; logic got, seen;
    drain();
    send_one(4'd0, 2'b00, 32'h7FFFFFFF, 32'd1, 16'h0, e, lat, bc, got);
    n_cmp++;
    if (got !== 1'b1 || e.r !== 32'h80000000 || e.v !== 1'b1) begin
      n_fail++;
      $display("FAIL add_ovf: got=%b result=%h ovf=%b want result=80000000 ovf=1", got, e.r, e.v);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.stickyOverflow !== 1'b1) begin
      n_fail++; $display("FAIL sticky_set: sticky=%b want 1", bus.stickyOverflow);
    end
    @(posedge clock); #1 bus.clearSticky = 1'b1;
    @(posedge clock); #1 bus.clearSticky = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (bus.stickyOverflow !== 1'b0) begin
      n_fail++; $display("FAIL sticky_clear: sticky=%b want 0", bus.stickyOverflow);
    end
    @(posedge clock); #1;
    bus.outReady = 1'b0; bus.aluControl = 4'd0; bus.sourceSelect = 2'b00;
    bus.operandA = 32'h80000000; bus.operandB = 32'h80000000; bus.inValid = 1'b1;
    @(posedge clock); #1 bus.inValid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock); seen = bus.outValid;
      @(posedge clock); #1;
    end
    bus.outReady = 1'b1; bus.clearSticky = 1'b1;
    @(posedge clock); #1 bus.clearSticky = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (seen !== 1'b1 || bus.stickyOverflow !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins: seen=%b sticky=%b want seen=1 sticky=1", seen,
               bus.stickyOverflow);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_backpressure();
    int idx, nout;
    logic [31:0] want;
    drain();
    idx = 0; nout = 0;
    for (int cyc = 0; cyc < 40 && nout < 3; cyc++) begin
      bus.outReady = (cyc >= 5); bus.inValid = (idx < 3); bus.aluControl = 4'd0;
      bus.sourceSelect = 2'b00; bus.operandA = 32'(100 + idx); bus.operandB = 32'(3 * idx);
      @(negedge clock);
      if (cyc >= 2 && cyc <= 4) begin
        n_cmp++;
        if (bus.inReady !== 1'b0 || bus.outValid !== 1'b1 || bus.result !== 32'd100) begin
          n_fail++;
          $display("FAIL bp_hold_c%0d: inReady=%b outValid=%b result=%0d want inReady=0 outValid=1 result=100",
                   cyc, bus.inReady, bus.outValid, bus.result);
        end
      end
      if (bus.outValid && bus.outReady) begin
        want = 32'(100 + 4 * nout);
        n_cmp++;
        if (bus.result !== want) begin
          n_fail++;
          $display("FAIL bp_order_%0d: result=%0d want %0d", nout, bus.result, want);
        end
        nout++;
      end
      if (bus.inValid && bus.inReady) idx++;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (nout != 3) begin
      n_fail++; $display("FAIL bp_count: emitted %0d want 3", nout);
    end
  endtask

  task automatic test_mul();
    exp_t e; int lat, bc; logic got;
    drain();
`ifdef ALU_MUL_EN
    send_one(4'd11, 2'b00, 32'h00010000, 32'h00010000, 16'h0, e, lat, bc, got);
    n_cmp++;
    if (got !== 1'b1 || e.r !== 32'h0 || e.v !== 1'b1 || lat != 33 || bc != 32) begin
      n_fail++;
      $display("FAIL mul_big: got=%b result=%h ovf=%b lat=%0d busy=%0d want result=0 ovf=1 lat=33 busy=32",
               got, e.r, e.v, lat, bc);
    end
    send_one(4'd11, 2'b00, 32'd12, 32'd13, 16'h0, e, lat, bc, got);
    n_cmp++;
    if (got !== 1'b1 || e.r !== 32'd156 || e.v !== 1'b0 || lat != 33) begin
      n_fail++;
      $display("FAIL mul_small: got=%b result=%0d ovf=%b lat=%0d want result=156 ovf=0 lat=33",
               got, e.r, e.v, lat);
    end
`else
    send_one(4'd11, 2'b00, 32'd12, 32'd13, 16'h0, e, lat, bc, got);
    n_cmp++;
    if (got !== 1'b1 || e.r !== 32'd0 || e.c !== 1'b0 || e.v !== 1'b0 || lat != 1 || bc != 0) begin
      n_fail++;
      $display("FAIL op11_illegal: got=%b result=%h cmp=%b ovf=%b lat=%0d busy=%0d want 0/0/0 lat=1 busy=0",
               got, e.r, e.c, e.v, lat, bc);
    end
`endif
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e, held_e;
    logic sticky_m, held, xfer_ovf;
    logic [31:0] b;
    drain();
    sticky_m = 1'b0; held = 1'b0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (cyc >= 600 && q.size() == 0) break;
      bus.inValid = (cyc < 600) && ($urandom_range(0, 9) < 7);
      bus.outReady = (cyc >= 600) || ($urandom_range(0, 9) < 7);
      bus.clearSticky = ($urandom_range(0, 9) == 0);
      bus.aluControl = 4'($urandom_range(0, 15));
      bus.sourceSelect = 2'($urandom_range(0, 3));
      bus.operandA = rand_word(); bus.operandB = rand_word();
      bus.immediate = 16'($urandom);
      @(negedge clock);
      n_cmp++;
      if (bus.stickyOverflow !== sticky_m) begin
        n_fail++;
        $display("FAIL rand_sticky_c%0d: sticky=%b want %b", cyc, bus.stickyOverflow, sticky_m);
      end
      if (held) begin
        n_cmp++;
        if (bus.outValid !== 1'b1 || bus.result !== held_e.r || bus.compareResult !== held_e.c ||
            bus.overflow !== held_e.v) begin
          n_fail++;
          $display("FAIL rand_hold_c%0d: outValid=%b result=%h want held result=%h", cyc,
                   bus.outValid, bus.result, held_e.r);
        end
      end
      xfer_ovf = 1'b0;
      if (bus.outValid) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra_c%0d: result=%h with nothing expected", cyc, bus.result);
        end else if (bus.result !== q[0].r || bus.compareResult !== q[0].c ||
                     bus.overflow !== q[0].v) begin
          n_fail++;
          $display("FAIL rand_result_c%0d: result=%h cmp=%b ovf=%b want result=%h cmp=%b ovf=%b",
                   cyc, bus.result, bus.compareResult, bus.overflow, q[0].r, q[0].c, q[0].v);
        end
        if (bus.outReady && q.size() != 0) begin
          e = q.pop_front();
          xfer_ovf = e.v;
        end
      end
      held = bus.outValid && !bus.outReady;
      held_e = '{bus.result, bus.compareResult, bus.overflow};
      if (xfer_ovf) sticky_m = 1'b1;
      else if (bus.clearSticky) sticky_m = 1'b0;
      if (bus.inValid && bus.inReady) begin
        b = sel_b(bus.sourceSelect, bus.operandB, bus.immediate);
        q.push_back(ref_alu(bus.operandA, b, bus.aluControl));
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: %0d results outstanding want 0", q.size());
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_throughput();
    test_imm_flags();
    test_overflow_sticky();
    test_backpressure();
    test_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_alu_stage.md
# pipelined_alu_stage

Parametrised, two-stage pipelined execute unit that replaces the flat combinational source-select/ALU pair behind the datapath controller. It accepts one operation per cycle over a valid/ready handshake, selects register or immediate operands, computes the result, compare flag and signed overflow, and holds them in an output register until the consumer takes them. It also keeps a sticky overflow flag and, optionally, an iterative multiplier.

## Interface
- WIDTH, 32, datapath width (≥8)
- IMM_WIDTH, 16, immediate width (≤WIDTH)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- inValid  in  1  request valid
- inReady  out  1  stage can accept request this cycle
- operandA  in  WIDTH  register operand A
- operandB  in  WIDTH  register operand B
- immediate  in  IMM_WIDTH  instruction immediate
- sourceSelect  in  2  00: A,B; 01: A,sext(imm); 10: A,zext(imm); 11: A,0
- aluControl  in  4  operation code (see Operation)
- outValid  out  1  result valid
- outReady  in  1  consumer accepts result
- result  out  WIDTH  operation result
- compareResult  out  1  compare/zero flag for branch resolution
- overflow  out  1  signed overflow of this result
- stickyOverflow  out  1  set by any transferred result with overflow=1
- clearSticky  in  1  synchronous clear of stickyOverflow
- busy  out  1  multi-cycle operation in progress

## Operation
- S1 (issue register): on inValid&&inReady captures opA, selected opB, aluControl; s1Valid←1.
- S2 (output register): on S1 advance captures result, compareResult, overflow; outValid←1.
- Advance S2: !outValid || outReady. Advance S1: s1Valid && op complete && S2 advance. inReady = !s1Valid || S1 advance (combinational, no bubble at full throughput).
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLTU, 7 SLL, 8 SRL, 9 SRA (shift amount = opB[$clog2(WIDTH)-1:0]), 10 EQ, 11 MUL (macro only), 12–15 illegal.
- SLT/SLTU/EQ: result = zero-extended compare bit; compareResult = same bit. All other ops: compareResult = (result==0).
- overflow: ADD/SUB signed two's-complement overflow; MUL as below; else 0. Result wraps modulo 2^WIDTH.
- Illegal op: result 0, compareResult 0, overflow 0; still flows through pipeline.
- stickyOverflow: set on cycle after outValid&&outReady&&overflow; cleared by clearSticky; simultaneous set and clear → set wins.
- Reset: inReady 0 during reset then 1; outValid 0, result 0, compareResult 0, overflow 0, stickyOverflow 0, busy 0, FSM IDLE.

## Timing
- Single-cycle ops: accepted at edge N → outValid at edge N+1 (visible after edge N+1, i.e. 2-register latency counting S1 capture). Throughput 1/cycle with outReady held high.
- Backpressure: outValid&&!outReady holds result/flags stable; S1 holds; inReady falls only when S1 full and cannot advance.
- MUL (macro on): FSM IDLE→MUL on S1 capture of op 11; WIDTH cycles shift-add, busy=1; MUL→DONE; DONE advances to S2 when allowed, →IDLE. Accept→outValid latency WIDTH+1 cycles; inReady=0 while busy.
- Reset asserted mid-MUL or with outValid pending: operation discarded, no output produced.

## Configuration
- ALU_MUL_EN defined: op 11 = unsigned multiply, result = low WIDTH bits of product, overflow = (upper WIDTH bits ≠ 0), iterative FSM present, busy functional.
- ALU_MUL_EN undefined: op 11 is illegal (result 0, single-cycle), no multiplier/FSM logic, busy tied 0.

## Test plan
- Reset: assert reset mid-stream → outValid=0, result=0, stickyOverflow=0, busy=0 immediately; no stale output after release.
- Throughput: WIDTH=32, ADD stream A=i, B=1, i=0..9, outReady=1 → results 1..10 back-to-back, no bubbles, inReady constantly 1.
- Immediate/flags: sourceSelect=01, A=5, imm=16'hFFFF, SUB → result 6, compareResult 0; EQ A=7,B=7 → result 1, compareResult 1; SLT A=0xFFFFFFFF, B=1 → 1; SLTU same → 0.
- Overflow/sticky: ADD 0x7FFFFFFF+1 → result 0x80000000, overflow 1, stickyOverflow set after transfer; clearSticky same cycle as new overflow transfer → stays 1.
- Backpressure: outReady=0 for 5 cycles with 3 ops offered → result held stable, inReady=0 after S1 fills, all 3 results emitted in order once outReady=1.
- ALU_MUL_EN: MUL 0x10000×0x10000 → result 0, overflow 1, busy for 32 cycles, outValid 33 cycles after accept; MUL 12×13 → 156, overflow 0; without macro op 11 → result 0 next stage.
